dmem_requester: RTL and testbench

//  Load/store initiator that drives the synchronous byte-strobed data RAM on behalf of the CPU.
//  - Accepts one RV32 load/store per valid/ready handshake and range/alignment-checks it.
//  - Generates RAM address, lane-replicated write data and strobes.
//  - Waits out the RAM's one-cycle read latency, then returns a lane-extracted,

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_load_align.sv | 29 ++
 rtl/dmem_requester.sv | 150 +++++++++++++++
 tb/tb_dmem_requester.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory requester: RV32 load/store width
// codes, the controller state encoding and a funct3 legality helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // state | meaning
    // IDLE  | ready for a new request
    // WAIT  | load issued, RAM read data arrives next cycle
    // RESP  | response presented, waiting for rsp_ready_i
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Unsigned widths only make sense for loads; stores with BU/HU are rejected.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of a RAM word and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[8*off_i +: 8];
    assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    // Extension by access width; anything else returns the full word.
    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_requester.sv
// Load/store initiator for the synchronous byte-strobed data RAM. One
// transaction in flight; RAM signals are driven combinationally in the
// accept cycle, load data is captured one cycle later.
module dmem_requester
    import dmem_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [2:0]    req_funct3_i,
    input  logic [31:0]   req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          mem_en_o,
    output logic          mem_wen_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [3:0]    mem_wstrb_o,
    input  logic [31:0]   mem_rdata_i
);

    dmem_state_e state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        accept;
    logic        access;
    logic [31:0] load_data;

    assign req_ready_o  = (state_q == IDLE);
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_rdata_o  = rdata_q;
    assign rsp_err_o    = err_q;

    assign accept       = req_valid_i & req_ready_o;
    assign out_of_range = |(req_addr_i >> (AW + 2));
    assign req_err      = misaligned | out_of_range | f3_illegal(req_we_i, req_funct3_i);
    assign access       = accept & ~req_err;

    // Alignment requirement depends on access width.
    always_comb begin
        misaligned = 1'b0;
        case (req_funct3_i)
            F3_H, F3_HU: misaligned = req_addr_i[0];
            F3_W:        misaligned = |req_addr_i[1:0];
            default:     misaligned = 1'b0;
        endcase
    end

    assign mem_en_o   = access;
    assign mem_wen_o  = access & req_we_i;
    assign mem_addr_o = access ? req_addr_i[AW+1:2] : '0;

    // Store data is replicated across lanes so the strobes alone pick the target bytes.
    always_comb begin
        mem_wdata_o = 32'd0;
        mem_wstrb_o = 4'd0;
        if (access && req_we_i) begin
            case (req_funct3_i)
                F3_B: begin
                    mem_wdata_o = {4{req_wdata_i[7:0]}};
                    mem_wstrb_o = 4'b0001 << req_addr_i[1:0];
                end
                F3_H: begin
                    mem_wdata_o = {2{req_wdata_i[15:0]}};
                    mem_wstrb_o = 4'b0011 << {req_addr_i[1], 1'b0};
                end
                default: begin
                    mem_wdata_o = req_wdata_i;
                    mem_wstrb_o = 4'b1111;
                end
            endcase
        end
    end

    dmem_load_align u_load_align (
        .word_i   (mem_rdata_i),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (load_data)
    );

    // Controller next-state and response capture.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    off_d   = req_addr_i[1:0];
                    f3_d    = req_funct3_i;
                    rdata_d = 32'd0;
                    err_d   = req_err;
                    state_d = (req_err || req_we_i) ? RESP : WAIT;
                end
            end
            WAIT: begin
                rdata_d = load_data;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset drops any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_requester.sv
// Directed bench for dmem_requester with a behavioural byte-strobed RAM.
module tb_dmem_requester;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_en_o;
    logic        mem_wen_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int en_snap;

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    dmem_requester #(.MEM_DEPTH(256)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_en_o     (mem_en_o),
        .mem_wen_o    (mem_wen_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Synchronous RAM: byte-strobed write, registered read.
    always @(posedge clk) begin
        if (mem_en_o) begin
            en_cnt = en_cnt + 1;
            for (int b = 0; b < 4; b++)
                if (mem_wen_o && mem_wstrb_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            mem_rdata_i <= ram[mem_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
    endtask

    task automatic handshake(input string tag);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        #1;
        chk({tag, " rsp_valid_after"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, " ready_after"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    // One complete transaction with exact-latency checks.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic exp_err,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata);
        logic [31:0] exp_addr;
        exp_addr = exp_err ? 32'd0 : {24'd0, addr[9:2]};
        @(negedge clk);
        drive(we, f3, addr, wd);
        #1;
        chk({tag, " req_ready"}, {31'd0, req_ready_o}, 32'd1);
        chk({tag, " mem_en"}, {31'd0, mem_en_o}, {31'd0, ~exp_err});
        chk({tag, " mem_wen"}, {31'd0, mem_wen_o}, {31'd0, we & ~exp_err});
        chk({tag, " mem_addr"}, {24'd0, mem_addr_o}, exp_addr);
        chk({tag, " wstrb"}, {28'd0, mem_wstrb_o}, {28'd0, exp_strb});
        if (we && !exp_err) chk({tag, " wdata"}, mem_wdata_o, exp_wdata);
        @(negedge clk);
        req_valid_i = 1'b0;
        #1;
        if (!we && !exp_err) begin
            chk({tag, " rsp_valid_n1"}, {31'd0, rsp_valid_o}, 32'd0);
            @(negedge clk);
            #1;
        end
        chk({tag, " rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        chk({tag, " rdata"}, rsp_rdata_o, exp_rdata);
        chk({tag, " err"}, {31'd0, rsp_err_o}, {31'd0, exp_err});
        handshake(tag);
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i   = 32'd0;
        req_wdata_i  = 32'd0;
        rsp_ready_i  = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        #12;
        chk("rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst rdata", rsp_rdata_o, 32'd0);
        chk("rst err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst mem_en", {31'd0, mem_en_o}, 32'd0);
        chk("rst wstrb", {28'd0, mem_wstrb_o}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Word store / load
        xact("SW10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'd0);
        xact("LW10", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 4'b0000, 32'd0, 32'hDEADBEEF);

        // Byte store into lane 3 -> word 0x80ADBEEF
        xact("SB13", 1'b1, 3'b000, 32'h13, 32'h00000080, 1'b0, 4'b1000, 32'h80808080, 32'd0);
        xact("LB13", 1'b0, 3'b000, 32'h13, 32'd0, 1'b0, 4'b0000, 32'd0, 32'hFFFFFF80);
        xact("LBU13", 1'b0, 3'b100, 32'h13, 32'd0, 1'b0, 4'b0000, 32'd0, 32'h00000080);

        // Upper half store -> word 0x8001BEEF
        xact("SH12", 1'b1, 3'b001, 32'h12, 32'h00008001, 1'b0, 4'b1100, 32'h80018001, 32'd0);
        xact("LH12", 1'b0, 3'b001, 32'h12, 32'd0, 1'b0, 4'b0000, 32'd0, 32'hFFFF8001);
        xact("LHU12", 1'b0, 3'b101, 32'h12, 32'd0, 1'b0, 4'b0000, 32'd0, 32'h00008001);
        xact("LW10b", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 4'b0000, 32'd0, 32'h8001BEEF);
        xact("LB10", 1'b0, 3'b000, 32'h10, 32'd0, 1'b0, 4'b0000, 32'd0, 32'hFFFFFFEF);
        xact("LH10", 1'b0, 3'b001, 32'h10, 32'd0, 1'b0, 4'b0000, 32'd0, 32'hFFFFBEEF);
        xact("LBU11", 1'b0, 3'b100, 32'h11, 32'd0, 1'b0, 4'b0000, 32'd0, 32'h000000BE);

        // Last in-range word
        xact("SW3FC", 1'b1, 3'b010, 32'h3FC, 32'h12345678, 1'b0, 4'b1111, 32'h12345678, 32'd0);
        xact("LW3FC", 1'b0, 3'b010, 32'h3FC, 32'd0, 1'b0, 4'b0000, 32'd0, 32'h12345678);

        // Restore word 0x10, then error cases must not touch RAM
        xact("SW10r", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'd0);
        en_snap = en_cnt;
        xact("LW11", 1'b0, 3'b010, 32'h11, 32'd0, 1'b1, 4'b0000, 32'd0, 32'd0);
        xact("SH13", 1'b1, 3'b001, 32'h13, 32'h0000AAAA, 1'b1, 4'b0000, 32'd0, 32'd0);
        xact("SW400", 1'b1, 3'b010, 32'h400, 32'h55555555, 1'b1, 4'b0000, 32'd0, 32'd0);
        xact("LF3_011", 1'b0, 3'b011, 32'h10, 32'd0, 1'b1, 4'b0000, 32'd0, 32'd0);
        xact("SBU", 1'b1, 3'b100, 32'h10, 32'h000000FF, 1'b1, 4'b0000, 32'd0, 32'd0);
        chk("err no mem_en", en_cnt, en_snap);
        xact("LW10c", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 4'b0000, 32'd0, 32'hDEADBEEF);

        // Back-pressure: response held, new request blocked
        @(negedge clk);
        drive(1'b0, 3'b010, 32'h10, 32'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h20, 32'h11111111);
        en_snap = en_cnt;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("hold rdata", rsp_rdata_o, 32'hDEADBEEF);
            chk("hold err", {31'd0, rsp_err_o}, 32'd0);
            chk("hold req_ready", {31'd0, req_ready_o}, 32'd0);
            chk("hold mem_en", {31'd0, mem_en_o}, 32'd0);
            @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("hs mem_en", {31'd0, mem_en_o}, 32'd0);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        #1;
        chk("blocked no access", en_cnt, en_snap);
        chk("post-hs req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("post-hs mem_en", {31'd0, mem_en_o}, 32'd1);
        chk("post-hs wstrb", {28'd0, mem_wstrb_o}, 32'h0000000F);
        @(negedge clk);
        req_valid_i = 1'b0;
        #1;
        chk("SW20 rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("SW20 err", {31'd0, rsp_err_o}, 32'd0);
        handshake("SW20");
        xact("LW20", 1'b0, 3'b010, 32'h20, 32'd0, 1'b0, 4'b0000, 32'd0, 32'h11111111);

        // Reset while waiting for load data
        @(negedge clk);
        drive(1'b0, 3'b010, 32'h10, 32'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid-rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("mid-rst req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("mid-rst rdata", rsp_rdata_o, 32'd0);
        chk("mid-rst err", {31'd0, rsp_err_o}, 32'd0);
        chk("mid-rst mem_en", {31'd0, mem_en_o}, 32'd0);
        @(negedge clk);
        chk("rst held rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        rst_ni = 1'b1;
        xact("LW10d", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 4'b0000, 32'd0, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
